// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types: broadcast packet layout and functional-unit indices.
package cdb_arbiter_pkg;

  typedef struct packed {
    logic [31:0] result;
    logic [3:0]  dest_ROB_entry;
    logic        branch_result;
    logic        load_step1;
  } CDB_packet_t;

  localparam int unsigned CDB_PKT_W = $bits(CDB_packet_t);

  typedef enum logic [1:0] {
    FU_ADD = 2'd0,
    FU_BR  = 2'd1,
    FU_LD  = 2'd2,
    FU_MUL = 2'd3
  } fu_idx_e;

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo NUM_FU.
module rr_picker #(
  parameter int unsigned NUM_FU = 4,
  parameter int unsigned PTR_W  = $clog2(NUM_FU)
) (
  input  logic [NUM_FU-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_FU-1:0] gnt,
  output logic [PTR_W-1:0]  gnt_idx
);

  logic        found;
  int unsigned idx;

  // Walking from ptr in ascending order is the rotate / priority-encode /
  // unrotate in one pass; ptr is always < NUM_FU so one subtraction wraps.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: round-robin grant among FUs, registered broadcast.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_FU = 4,
  parameter int unsigned PTR_W  = $clog2(NUM_FU)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_FU-1:0]        fu_valid,
  input  CDB_packet_t [NUM_FU-1:0] fu_pkt,
  input  logic                     cdb_stall,
  input  logic                     flush,
  output logic [NUM_FU-1:0]        fu_yumi,
  output logic                     cdb_valid,
  output CDB_packet_t              cdb_pkt
);

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  rr_ptr_next;
  logic [NUM_FU-1:0] gnt;
  logic [PTR_W-1:0]  gnt_idx;
  logic              grant_ok;
  logic              grant;

  rr_picker #(
    .NUM_FU (NUM_FU),
    .PTR_W  (PTR_W)
  ) u_picker (
    .req     (fu_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Grant is only issued when the bus can actually accept the packet.
  always_comb begin
    grant_ok    = reset && !cdb_stall && !flush;
    grant       = grant_ok && (|fu_valid);
    fu_yumi     = grant_ok ? gnt : '0;
    rr_ptr_next = (gnt_idx == PTR_W'(NUM_FU - 1)) ? '0 : gnt_idx + PTR_W'(1);
  end

  // Output register and pointer; flush beats stall, stall re-presents.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cdb_valid <= 1'b0;
      cdb_pkt   <= '0;
      rr_ptr    <= '0;
    end else if (flush) begin
      cdb_valid <= 1'b0;
    end else if (cdb_stall) begin
      cdb_valid <= cdb_valid;
    end else if (grant) begin
      cdb_valid <= 1'b1;
      cdb_pkt   <= fu_pkt[gnt_idx];
      rr_ptr    <= rr_ptr_next;
    end else begin
      cdb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with hand-computed expectations.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       fu_valid;
  CDB_packet_t [3:0] fu_pkt;
  logic             cdb_stall;
  logic             flush;
  logic [3:0]       fu_yumi;
  logic             cdb_valid;
  CDB_packet_t      cdb_pkt;

  int unsigned total  = 0;
  int unsigned passed = 0;

  cdb_arbiter #(
    .NUM_FU (4),
    .PTR_W  (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .fu_valid  (fu_valid),
    .fu_pkt    (fu_pkt),
    .cdb_stall (cdb_stall),
    .flush     (flush),
    .fu_yumi   (fu_yumi),
    .cdb_valid (cdb_valid),
    .cdb_pkt   (cdb_pkt)
  );

  always #5 clk = ~clk;

  function automatic CDB_packet_t mk(input logic [31:0] res, input logic [3:0] rob);
    CDB_packet_t p;
    p.result         = res;
    p.dest_ROB_entry = rob;
    p.branch_result  = rob[0];
    p.load_step1     = rob[1];
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grant-path invariants every cycle.
  always @(negedge clk) begin
    chk("onehot", 64'($onehot0(fu_yumi)), 64'(1));
    chk("yumi_without_valid", 64'(fu_yumi & ~fu_valid), 64'(0));
  end

  initial begin
    reset     = 1'b0;
    cdb_stall = 1'b0;
    flush     = 1'b0;
    fu_valid  = 4'b1111;
    for (int i = 0; i < 4; i++) fu_pkt[i] = mk(32'h100 + 32'(i), 4'(i));

    // Reset held with all FUs valid
    #1;
    chk("rst_yumi", 64'(fu_yumi), 64'(4'b0000));
    tick();
    tick();
    chk("rst_yumi2", 64'(fu_yumi), 64'(4'b0000));
    chk("rst_valid", 64'(cdb_valid), 64'(0));
    chk("rst_pkt", 64'(cdb_pkt), 64'(0));

    // Round robin 0,1,2,3,0
    reset = 1'b1;
    #1;
    chk("rr_yumi0", 64'(fu_yumi), 64'(4'b0001));
    tick();
    chk("rr_cdb0", 64'(cdb_pkt.dest_ROB_entry), 64'(0));
    chk("rr_val0", 64'(cdb_valid), 64'(1));
    chk("rr_yumi1", 64'(fu_yumi), 64'(4'b0010));
    tick();
    chk("rr_cdb1", 64'(cdb_pkt.dest_ROB_entry), 64'(1));
    chk("rr_yumi2", 64'(fu_yumi), 64'(4'b0100));
    tick();
    chk("rr_cdb2", 64'(cdb_pkt.dest_ROB_entry), 64'(2));
    chk("rr_yumi3", 64'(fu_yumi), 64'(4'b1000));
    tick();
    chk("rr_cdb3", 64'(cdb_pkt.dest_ROB_entry), 64'(3));
    chk("rr_res3", 64'(cdb_pkt.result), 64'(32'h103));
    chk("rr_yumi4", 64'(fu_yumi), 64'(4'b0001));
    tick();
    chk("rr_cdb4", 64'(cdb_pkt.dest_ROB_entry), 64'(0));
    // rr_ptr now 1

    // Single requester FU2
    fu_valid  = 4'b0100;
    fu_pkt[2] = mk(32'h0000_0005, 4'd7);
    #1;
    chk("single_yumi", 64'(fu_yumi), 64'(4'b0100));
    tick();
    chk("single_valid", 64'(cdb_valid), 64'(1));
    chk("single_res", 64'(cdb_pkt.result), 64'(5));
    chk("single_rob", 64'(cdb_pkt.dest_ROB_entry), 64'(7));
    fu_valid = 4'b0000;
    #1;
    chk("idle_yumi", 64'(fu_yumi), 64'(4'b0000));
    tick();
    chk("idle_valid", 64'(cdb_valid), 64'(0));
    // rr_ptr now 3

    // Stall with broadcast pending (FU1 via wrap 3->0->1)
    fu_valid  = 4'b0010;
    fu_pkt[1] = mk(32'h11, 4'd1);
    #1;
    chk("pre_stall_yumi", 64'(fu_yumi), 64'(4'b0010));
    tick();
    chk("pre_stall_rob", 64'(cdb_pkt.dest_ROB_entry), 64'(1));
    // rr_ptr now 2
    for (int i = 0; i < 4; i++) fu_pkt[i] = mk(32'h200 + 32'(i), 4'(i));
    fu_valid  = 4'b1111;
    cdb_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_yumi", 64'(fu_yumi), 64'(4'b0000));
      tick();
      chk("stall_valid", 64'(cdb_valid), 64'(1));
      chk("stall_res", 64'(cdb_pkt.result), 64'(32'h11));
      chk("stall_rob", 64'(cdb_pkt.dest_ROB_entry), 64'(1));
    end
    cdb_stall = 1'b0;
    #1;
    chk("resume_yumi", 64'(fu_yumi), 64'(4'b0100));
    tick();
    chk("resume_rob", 64'(cdb_pkt.dest_ROB_entry), 64'(2));
    chk("resume_res", 64'(cdb_pkt.result), 64'(32'h202));
    // rr_ptr now 3, broadcast pending

    // Flush together with stall: flush wins
    fu_valid  = 4'b1010;
    flush     = 1'b1;
    cdb_stall = 1'b1;
    #1;
    chk("flush_yumi", 64'(fu_yumi), 64'(4'b0000));
    tick();
    chk("flush_valid", 64'(cdb_valid), 64'(0));
    flush     = 1'b0;
    cdb_stall = 1'b0;
    #1;
    chk("post_flush_yumi", 64'(fu_yumi), 64'(4'b1000));
    tick();
    chk("post_flush_rob", 64'(cdb_pkt.dest_ROB_entry), 64'(3));
    // rr_ptr now 0; bring it back to 3 via FU2
    fu_valid = 4'b0100;
    #1;
    chk("ptr_set_yumi", 64'(fu_yumi), 64'(4'b0100));
    tick();

    // Wrap/fairness with rr_ptr=3, fu_valid=1001
    fu_valid = 4'b1001;
    #1;
    chk("wrap_yumi_a", 64'(fu_yumi), 64'(4'b1000));
    tick();
    chk("wrap_rob_a", 64'(cdb_pkt.dest_ROB_entry), 64'(3));
    chk("wrap_yumi_b", 64'(fu_yumi), 64'(4'b0001));
    tick();
    chk("wrap_rob_b", 64'(cdb_pkt.dest_ROB_entry), 64'(0));
    chk("wrap_yumi_c", 64'(fu_yumi), 64'(4'b1000));
    tick();
    chk("wrap_rob_c", 64'(cdb_pkt.dest_ROB_entry), 64'(3));
    chk("wrap_flags", 64'({cdb_pkt.branch_result, cdb_pkt.load_step1}), 64'(2'b11));

    // Reset mid-operation drops the pending broadcast
    reset = 1'b0;
    #1;
    chk("midrst_yumi", 64'(fu_yumi), 64'(4'b0000));
    tick();
    chk("midrst_valid", 64'(cdb_valid), 64'(0));
    chk("midrst_pkt", 64'(cdb_pkt), 64'(0));
    reset = 1'b1;
    #1;
    chk("midrst_first", 64'(fu_yumi), 64'(4'b0001));
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single Common Data Bus between NUM_FU functional units (add/sub ALU, branch, load, mul).
- Each FU holds its result under a valid/yumi handshake. This block picks one FU per cycle in round-robin order, pulses that FU's yumi, and registers the packet onto the CDB.
- Reservation stations and the ROB snoop the CDB one cycle after the grant.

Parameters:
- NUM_FU, 4, number of requesting functional units (2..8).
- PTR_W, $clog2(NUM_FU), width of the round-robin pointer.

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-low reset.
- fu_valid  input  NUM_FU  bit i high: FU i holds a finished result.
- fu_pkt  input  NUM_FU x CDB_packet_t  packet offered by each FU.
- cdb_stall  input  1  downstream (ROB writeback) cannot take a new broadcast this cycle.
- flush  input  1  mispredict squash; drop the in-flight broadcast.
- fu_yumi  output  NUM_FU  one-hot grant; FU i's packet is consumed at this clock edge.
- cdb_valid  output  1  cdb_pkt is a valid broadcast.
- cdb_pkt  output  CDB_packet_t  registered broadcast packet.

Behaviour:
- Reset values (reset low at a clock edge): cdb_valid=0, cdb_pkt=0, rr_ptr=0. fu_yumi is forced to 0 while reset is low.
- Grant (combinational):
  - Search fu_valid starting at index rr_ptr, ascending, wrapping modulo NUM_FU.
  - The first set bit wins, and fu_yumi gets exactly that one bit.
  - fu_yumi is never asserted for an FU whose fu_valid is low.
- Grant suppression: fu_yumi=0 when cdb_stall=1, flush=1, reset=0, or fu_valid=0.
- Capture: on an edge with a grant to FU g, cdb_pkt<=fu_pkt[g], cdb_valid<=1, rr_ptr<=(g+1) mod NUM_FU.
- Latency: one cycle from grant to broadcast. Throughput: one packet per cycle with no bubbles.
- No grant and cdb_stall=0: cdb_valid<=0. cdb_pkt holds its value (don't-care), and rr_ptr is unchanged.
- cdb_stall=1: cdb_valid and cdb_pkt hold their values, so a pending broadcast is re-presented. rr_ptr is unchanged and no FU is acknowledged.
- flush=1: cdb_valid<=0 on that edge and no grant. rr_ptr is unchanged. flush overrides cdb_stall.
- Reset mid-operation: the pending broadcast is lost and the FUs keep their packets, because no yumi was issued.
- Fairness: a continuously-valid FU waits at most NUM_FU-1 grants.
- Packet fields: result(32), dest_ROB_entry(4), branch_result(1) and load_step1(1) pass through unmodified.

Decomposition:
- The shared structs package already holds CDB_packet_t. Add CDB_PKT_W and a FU index enum (FU_ADD=0, FU_BR=1, FU_LD=2, FU_MUL=3) there.
- Sub-module rr_picker (NUM_FU): combinational rotate / priority-encode / unrotate. Inputs req, ptr; outputs one-hot gnt and binary gnt_idx.
- The top level holds rr_ptr, the output register and the stall/flush muxing.

Test Plan:
- Reset: hold reset=0 for 2 cycles with all fu_valid=1 -> fu_yumi=0000, cdb_valid=0; after release, first grant is FU0.
- Round-robin: fu_valid=1111 held, each FU re-presents after yumi, dest_ROB_entry = FU index -> yumi order 0,1,2,3,0; cdb_pkt.dest_ROB_entry follows one cycle later.
- Single requester: only FU2 valid with result=0x0000_0005, dest_ROB_entry=7 -> fu_yumi=0100 that cycle; next cycle cdb_valid=1, result=5, rob=7; cycle after, cdb_valid=0.
- Stall: cdb_stall=1 for 3 cycles while a broadcast is pending -> cdb_pkt unchanged, fu_yumi=0; on release, the next grant resumes from the saved rr_ptr.
- Flush: flush=1 with broadcast pending and FU1 valid -> next cycle cdb_valid=0, FU1 not acked, rr_ptr unchanged.
- Wrap/fairness: rr_ptr=3, fu_valid=1001 -> grant FU3, then FU0, then FU3. Assert a one-hot check and no yumi without valid on every cycle.
